// File: rtl/raster_engine.sv
// Command-driven rasterizer: fill, point and clipped rectangle writes into a linear framebuffer.
// Define RASTER_ENGINE_OUTLINE_EN to enable command 4 (rectangle outline); otherwise it is a NOP.
module raster_engine #(
   parameter int FB_W = 214,
   parameter int FB_H = 160,
   parameter int COLOUR_W = 3,
   parameter int A_WIDTH = 16,
   localparam int X_W = $clog2(FB_W),
   localparam int Y_W = $clog2(FB_H)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          command,
   input  logic [COLOUR_W-1:0] colour,
   input  logic [X_W-1:0]      x0,
   input  logic [X_W-1:0]      x1,
   input  logic [Y_W-1:0]      y0,
   input  logic [Y_W-1:0]      y1,
   input  logic                execute_request,
   output logic                ready,
   output logic                done,
   output logic [A_WIDTH-1:0]  fb_addr,
   output logic                fb_write_en,
   output logic [COLOUR_W-1:0] fb_pixel
);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FINISH} state_t;

   localparam logic [A_WIDTH-1:0] FBW_A = A_WIDTH'(FB_W);
   localparam logic [X_W-1:0]     XMAX  = X_W'(FB_W - 1);
   localparam logic [Y_W-1:0]     YMAX  = Y_W'(FB_H - 1);

   state_t state_q, state_d;
   logic [X_W-1:0] cx_q, cx_d, x0_q, x0_d, x1_q, x1_d;
   logic [Y_W-1:0] cy_q, cy_d, y0_q, y0_d, y1_q, y1_d;
   logic clipx_q, clipx_d, clipy_q, clipy_d, outl_q, outl_d;
   logic [A_WIDTH-1:0] row_q, row_d, addr_q, addr_d;
   logic [COLOUR_W-1:0] pix_q, pix_d;

   logic is_fill, is_point, is_box, is_outl;
   logic [X_W-1:0] xlo, xhi, ax0, ax1;
   logic [Y_W-1:0] ylo, yhi, ay0, ay1;
   logic clip_x, clip_y, has_pix;
   logic mid, row_end;
   logic [A_WIDTH-1:0] base0;

   // Command decode and corner normalisation, evaluated on the accept cycle.
   always_comb begin
      is_fill  = 1'b0;
      is_point = 1'b0;
      is_box   = 1'b0;
      is_outl  = 1'b0;
      case (command)
         3'd1: is_fill  = 1'b1;
         3'd2: is_point = 1'b1;
         3'd3: is_box   = 1'b1;
`ifdef RASTER_ENGINE_OUTLINE_EN
         3'd4: is_outl  = 1'b1;
`endif
         default: ;
      endcase
      xlo = (x0 <= x1) ? x0 : x1;
      xhi = (x0 <= x1) ? x1 : x0;
      ylo = (y0 <= y1) ? y0 : y1;
      yhi = (y0 <= y1) ? y1 : y0;
      clip_x = 32'(xhi) > 32'(FB_W - 1);
      clip_y = 32'(yhi) > 32'(FB_H - 1);
      ax0 = xlo;
      ax1 = clip_x ? XMAX : xhi;
      ay0 = ylo;
      ay1 = clip_y ? YMAX : yhi;
      if (is_fill) begin
         ax0 = '0;
         ax1 = XMAX;
         ay0 = '0;
         ay1 = YMAX;
         clip_x = 1'b0;
         clip_y = 1'b0;
      end else if (is_point) begin
         ax0 = x0;
         ax1 = x0;
         ay0 = y0;
         ay1 = y0;
         clip_x = 1'b0;
         clip_y = 1'b0;
      end
      has_pix = (is_fill | is_point | is_box | is_outl)
              && (32'(ax0) < 32'(FB_W)) && (32'(ay0) < 32'(FB_H));
      base0 = A_WIDTH'(ay0) * FBW_A;
   end

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      x0_d    = x0_q;
      x1_d    = x1_q;
      y0_d    = y0_q;
      y1_d    = y1_q;
      clipx_d = clipx_q;
      clipy_d = clipy_q;
      outl_d  = outl_q;
      row_d   = row_q;
      addr_d  = addr_q;
      pix_d   = pix_q;
      // Outline interior rows only touch the left and (unclipped) right edge.
      mid     = outl_q && (cy_q != y0_q) && !((cy_q == y1_q) && !clipy_q);
      row_end = (cx_q == x1_q) || (mid && clipx_q);
      case (state_q)
         S_IDLE: begin
            if (execute_request) begin
               if (has_pix) begin
                  state_d = S_DRAW;
                  cx_d    = ax0;
                  cy_d    = ay0;
                  x0_d    = ax0;
                  x1_d    = ax1;
                  y0_d    = ay0;
                  y1_d    = ay1;
                  clipx_d = clip_x;
                  clipy_d = clip_y;
                  outl_d  = is_outl;
                  row_d   = base0;
                  addr_d  = base0 + A_WIDTH'(ax0);
                  pix_d   = colour;
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_DRAW: begin
            if (row_end) begin
               if (cy_q == y1_q) begin
                  state_d = S_FINISH;
               end else begin
                  cy_d   = cy_q + 1'b1;
                  cx_d   = x0_q;
                  row_d  = row_q + FBW_A;
                  addr_d = row_q + FBW_A + A_WIDTH'(x0_q);
               end
            end else if (mid) begin
               cx_d   = x1_q;
               addr_d = row_q + A_WIDTH'(x1_q);
            end else begin
               cx_d   = cx_q + 1'b1;
               addr_d = addr_q + 1'b1;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cx_q    <= '0;
         cy_q    <= '0;
         x0_q    <= '0;
         x1_q    <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         clipx_q <= 1'b0;
         clipy_q <= 1'b0;
         outl_q  <= 1'b0;
         row_q   <= '0;
         addr_q  <= '0;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         clipx_q <= clipx_d;
         clipy_q <= clipy_d;
         outl_q  <= outl_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         pix_q   <= pix_d;
      end
   end

   assign ready       = (state_q == S_IDLE);
   assign done        = (state_q == S_FINISH);
   assign fb_write_en = (state_q == S_DRAW);
   assign fb_addr     = addr_q;
   assign fb_pixel    = pix_q;

endmodule

// File: tb/tb_raster_engine.sv
// Bench for raster_engine: vector table, reset and back-to-back sequences,
// and randomized commands checked against a pixel-enumeration model.
module tb_raster_engine;

   localparam int W = 214;
   localparam int H = 160;
`ifdef RASTER_ENGINE_OUTLINE_EN
   localparam bit OUTL = 1'b1;
`else
   localparam bit OUTL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  command = '0;
   logic [2:0]  colour = '0;
   logic [7:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
   logic        execute_request = 1'b0;
   logic        ready, done, fb_write_en;
   logic [15:0] fb_addr;
   logic [2:0]  fb_pixel;

   raster_engine dut (
      .clk(clk), .rst(rst), .command(command), .colour(colour),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1),
      .execute_request(execute_request), .ready(ready), .done(done),
      .fb_addr(fb_addr), .fb_write_en(fb_write_en), .fb_pixel(fb_pixel)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int wa[$], wp[$], wc[$], dc[$];
   int exp_q[$];
   int ntot = 0, npass = 0;

   always @(negedge clk) begin
      if (fb_write_en === 1'b1) begin
         wa.push_back(int'(fb_addr));
         wp.push_back(int'(fb_pixel));
         wc.push_back(cyc);
      end
      if (done === 1'b1) dc.push_back(cyc);
   end

   task automatic chk(input string nm, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic clr();
      wa.delete(); wp.delete(); wc.delete(); dc.delete();
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Enumerate every pixel the command should touch, in raster order.
   function automatic void build_exp(input int c, input int a0, input int a1,
                                     input int b0, input int b1);
      int lx, hx, ly, hy;
      bit clx, cly, outl;
      exp_q.delete();
      outl = 1'b0;
      clx = 1'b0;
      cly = 1'b0;
      if (c == 1) begin
         lx = 0; hx = W - 1; ly = 0; hy = H - 1;
      end else if (c == 2) begin
         if (a0 < W && b0 < H) exp_q.push_back(b0 * W + a0);
         return;
      end else if (c == 3 || (c == 4 && OUTL)) begin
         outl = (c == 4);
         lx = (a0 < a1) ? a0 : a1;
         hx = (a0 < a1) ? a1 : a0;
         ly = (b0 < b1) ? b0 : b1;
         hy = (b0 < b1) ? b1 : b0;
         clx = hx > W - 1;
         cly = hy > H - 1;
         if (clx) hx = W - 1;
         if (cly) hy = H - 1;
      end else begin
         return;
      end
      if (lx >= W || ly >= H) return;
      for (int y = ly; y <= hy; y++)
         for (int x = lx; x <= hx; x++)
            if (!outl || y == ly || x == lx || (x == hx && !clx) || (y == hy && !cly))
               exp_q.push_back(y * W + x);
   endfunction

   task automatic run_cmd(input string nm, input logic [2:0] c, input logic [2:0] col,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] b0, input logic [7:0] b1,
                          output int rn, output int rf, output int rl);
      int acc, t, bad, pbad;
      step();
      t = 0;
      while (ready !== 1'b1 && t < 50) begin step(); t++; end
      chk({nm, " ready_before"}, int'(ready === 1'b1), 1);
      clr();
      command = c; colour = col; x0 = a0; x1 = a1; y0 = b0; y1 = b1;
      execute_request = 1'b1;
      acc = cyc;
      step();
      execute_request = 1'b0;
      command = 3'($urandom); colour = 3'($urandom);
      x0 = 8'($urandom); x1 = 8'($urandom); y0 = 8'($urandom); y1 = 8'($urandom);
      t = 0;
      while (dc.size() == 0 && t < 40000) begin step(); t++; end
      chk({nm, " done_count"}, dc.size(), 1);
      build_exp(int'(c), int'(a0), int'(a1), int'(b0), int'(b1));
      chk({nm, " write_count"}, wa.size(), exp_q.size());
      bad = -1;
      pbad = 0;
      for (int i = 0; i < wa.size() && i < exp_q.size(); i++) begin
         if (bad < 0 && wa[i] != exp_q[i]) bad = i;
         if (wp[i] != int'(col)) pbad++;
      end
      chk({nm, " first_bad_addr_idx"}, bad, -1);
      chk({nm, " bad_pixels"}, pbad, 0);
      if (dc.size() > 0) begin
         if (wc.size() > 0) begin
            chk({nm, " first_write_cyc"}, wc[0] - acc, 1);
            chk({nm, " write_span"}, wc[wc.size()-1] - wc[0], wc.size() - 1);
            chk({nm, " done_after_last"}, dc[0] - wc[wc.size()-1], 1);
         end else begin
            chk({nm, " done_cyc_zero"}, dc[0] - acc, 1);
         end
         chk({nm, " ready_after_done"}, int'(ready === 1'b1), 1);
      end
      rn = wa.size();
      rf = (wa.size() > 0) ? wa[0] : -1;
      rl = (wa.size() > 0) ? wa[wa.size()-1] : -1;
   endtask

   typedef struct {
      logic [2:0] cmd;
      logic [2:0] col;
      logic [7:0] a0, a1, b0, b1;
      int n, first, last;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int rn, rf, rl, c0;
      int cmds[8];
      logic [7:0] a0, a1, b0, b1;
      cmds = '{0, 2, 3, 4, 5, 3, 3, 4};

      tbl[0] = '{3'd1, 3'd5, 8'd0,   8'd0,   8'd0,   8'd0,   34240, 0,     34239};
      tbl[1] = '{3'd3, 3'd3, 8'd10,  8'd12,  8'd5,   8'd6,   6,     1080,  1296};
      tbl[2] = '{3'd3, 3'd3, 8'd12,  8'd10,  8'd6,   8'd5,   6,     1080,  1296};
      tbl[3] = '{3'd3, 3'd1, 8'd220, 8'd230, 8'd0,   8'd5,   0,     -1,    -1};
      tbl[4] = '{3'd2, 3'd7, 8'd213, 8'd0,   8'd159, 8'd0,   1,     34239, 34239};
      tbl[5] = '{3'd2, 3'd7, 8'd214, 8'd0,   8'd0,   8'd0,   0,     -1,    -1};
      tbl[6] = '{3'd0, 3'd2, 8'd1,   8'd2,   8'd1,   8'd2,   0,     -1,    -1};
      tbl[7] = '{3'd7, 3'd2, 8'd1,   8'd2,   8'd1,   8'd2,   0,     -1,    -1};
      if (OUTL) tbl[8] = '{3'd4, 3'd6, 8'd0, 8'd2, 8'd0, 8'd2, 8, 0, 430};
      else      tbl[8] = '{3'd4, 3'd6, 8'd0, 8'd2, 8'd0, 8'd2, 0, -1, -1};
      tbl[9] = '{3'd3, 3'd4, 8'd200, 8'd250, 8'd150, 8'd200, 140, 32300, 34239};

      // Reset behaviour with a request held during reset.
      command = 3'd1; execute_request = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      execute_request = 1'b0;
      chk("rst ready", int'(ready), 1);
      chk("rst write_en", int'(fb_write_en), 0);
      chk("rst done", int'(done), 0);
      chk("rst addr", int'(fb_addr), 0);
      chk("rst pixel", int'(fb_pixel), 0);
      step();
      chk("rst no_writes", wa.size(), 0);

      foreach (tbl[i]) begin
         run_cmd($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].col,
                 tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, rn, rf, rl);
         chk($sformatf("vec%0d n", i), rn, tbl[i].n);
         chk($sformatf("vec%0d first", i), rf, tbl[i].first);
         chk($sformatf("vec%0d last", i), rl, tbl[i].last);
      end

      // Reset pulse in the middle of a fill.
      step();
      clr();
      command = 3'd1; colour = 3'd5; execute_request = 1'b1;
      step();
      execute_request = 1'b0;
      repeat (100) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst write_en", int'(fb_write_en), 0);
      chk("midrst ready", int'(ready), 1);
      chk("midrst writes_before", int'(wa.size() > 90), 1);
      clr();
      repeat (5) step();
      chk("midrst writes_after", wa.size(), 0);
      chk("midrst no_done", dc.size(), 0);

      // Back-to-back 1x1 rectangles with the request held high.
      clr();
      command = 3'd3; colour = 3'd2;
      x0 = 8'd5; x1 = 8'd5; y0 = 8'd5; y1 = 8'd5;
      execute_request = 1'b1;
      c0 = cyc;
      step();
      x0 = 8'd7; x1 = 8'd7; y0 = 8'd8; y1 = 8'd8; colour = 3'd6;
      repeat (3) step();
      execute_request = 1'b0;
      repeat (4) step();
      chk("b2b writes", wc.size(), 2);
      chk("b2b dones", dc.size(), 2);
      if (wc.size() == 2 && dc.size() == 2) begin
         chk("b2b w0_cyc", wc[0] - c0, 1);
         chk("b2b w1_cyc", wc[1] - c0, 4);
         chk("b2b d0_cyc", dc[0] - c0, 2);
         chk("b2b d1_cyc", dc[1] - c0, 5);
         chk("b2b a0", wa[0], 1075);
         chk("b2b a1", wa[1], 1719);
         chk("b2b p1", wp[1], 6);
      end

      // Randomized commands against the model.
      for (int i = 0; i < 40; i++) begin
         a0 = 8'($urandom_range(0, 240));
         a1 = a0 + 8'($urandom_range(0, 15));
         b0 = 8'($urandom_range(0, 170));
         b1 = b0 + 8'($urandom_range(0, 12));
         if ($urandom_range(0, 1) == 1) begin
            {a0, a1} = {a1, a0};
            {b0, b1} = {b1, b0};
         end
         run_cmd($sformatf("rnd%0d", i), 3'(cmds[$urandom_range(0, 7)]),
                 3'($urandom), a0, a1, b0, b1, rn, rf, rl);
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
